// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command encodings, frame geometry
// and the master state enum.
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      SEND,
      TURN,
      RECV,
      DONE
   } state_t;

   // Only read-data frames are followed by a turnaround and a reply byte.
   function automatic logic has_reply(input logic [1:0] cmd);
      has_reply = (cmd == CMD_RD_DATA);
   endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master issuing 10-bit {cmd, payload} frames at one bit per clk and
// capturing an 8-bit MISO reply for read-data frames.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned RD_TURNAROUND = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_type,
   input  logic [DATA_BITS-1:0] cmd_data,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO,
   output logic                 rsp_valid,
   output logic [DATA_BITS-1:0] rsp_data,
   output logic                 frame_done
);

   localparam logic [3:0] SEND_LAST = 4'(FRAME_BITS - 1);
   localparam logic [3:0] TURN_LAST = 4'(RD_TURNAROUND - 1);
   localparam logic [3:0] RECV_LAST = 4'(DATA_BITS - 1);

   state_t                 state;
   state_t                 state_d;
   logic [3:0]             cnt;
   logic [FRAME_BITS-1:0]  shift_out;
   logic [DATA_BITS-1:0]   shift_in;
   logic [1:0]             cmd_q;
   logic                   accept;
   logic                   active_d;
   logic                   reply_done;

   assign cmd_ready  = (state == IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign active_d   = (state_d == SELECT) || (state_d == SEND) ||
                       (state_d == TURN)   || (state_d == RECV);
   assign reply_done = (state == RECV) && (state_d == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // NOTE: state_d takes its default before the case so no path can infer a latch.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (cmd_valid) state_d = SELECT;
         SELECT:  state_d = SEND;
         SEND:    if (cnt == SEND_LAST) state_d = has_reply(cmd_q) ? TURN : DONE;
         TURN:    if (cnt == TURN_LAST) state_d = RECV;
         RECV:    if (cnt == RECV_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin outputs are computed from state_d so they change on the same edge as the state.
   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the shift registers are individual flops rather than a RAM array, so they take the reset too.
         cnt        <= '0;
         shift_out  <= '0;
         shift_in   <= '0;
         cmd_q      <= CMD_WR_ADDR;
         SS_n       <= 1'b1;
         MOSI       <= 1'b0;
         frame_done <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
      end else begin
         cnt <= ((state_d == state) && (state != IDLE)) ? cnt + 4'd1 : 4'd0;

         if (accept) begin
            shift_out <= {cmd_type, cmd_data};
            cmd_q     <= cmd_type;
         end else if (state_d == SEND) begin
            shift_out <= shift_out << 1;
         end

         if (state == RECV) shift_in <= {shift_in[DATA_BITS-2:0], MISO};

         SS_n <= !active_d;
         case (state_d)
            SELECT:  MOSI <= cmd_type[1];
            SEND:    MOSI <= shift_out[FRAME_BITS-1];
            default: MOSI <= 1'b0;
         endcase

         frame_done <= (state_d == DONE);
         rsp_valid  <= reply_done;
         if (reply_done) rsp_data <= {shift_in[DATA_BITS-2:0], MISO};
      end
   end

endmodule
